// File: rtl/uvma_udma_rx_ch_rtl_ctrl_if.sv
// Rx beat stream and L2 write port of the uDMA Rx channel controller.
// master = the channel controller, slave = peripheral FIFO / L2 arbiter side.
interface uvma_udma_rx_ch_rtl_ctrl_if #(
  parameter int L2_AWIDTH = 19
);
  logic                 ch_valid_i;
  logic [31:0]          ch_data_i;
  logic                 ch_ready_o;
  logic                 l2_req_o;
  logic                 l2_gnt_i;
  logic [L2_AWIDTH-1:0] l2_addr_o;
  logic [31:0]          l2_wdata_o;
  logic [3:0]           l2_be_o;

  modport master (
    input  ch_valid_i, ch_data_i, l2_gnt_i,
    output ch_ready_o, l2_req_o, l2_addr_o, l2_wdata_o, l2_be_o
  );

  modport slave (
    output ch_valid_i, ch_data_i, l2_gnt_i,
    input  ch_ready_o, l2_req_o, l2_addr_o, l2_wdata_o, l2_be_o
  );
endinterface

// File: rtl/uvma_udma_rx_ch_rtl_ctrl.sv
// uDMA Rx channel controller: buffers peripheral beats and writes them to an L2 window.
// Optional overflow counter (port ovf_cnt_o) enabled by defining UVMA_UDMA_RX_CH_OVF_CNT_EN.
module uvma_udma_rx_ch_rtl_ctrl #(
  parameter int L2_AWIDTH  = 19,
  parameter int TRANS_SIZE = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [L2_AWIDTH-1:0]  cfg_start_addr_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic                  cfg_continuous_i,
  input  logic                  cfg_en_i,
  input  logic                  cfg_clr_i,
  output logic                  cfg_en_o,
  output logic                  cfg_pending_o,
  output logic [L2_AWIDTH-1:0]  cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0] cfg_bytes_left_o,
`ifdef UVMA_UDMA_RX_CH_OVF_CNT_EN
  output logic [7:0]            ovf_cnt_o,
`endif
  output logic                  evt_eot_o,
  uvma_udma_rx_ch_rtl_ctrl_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  function automatic logic [2:0] beat_bytes(input logic [1:0] ds);
    case (ds)
      2'd0:    beat_bytes = 3'd1;
      2'd1:    beat_bytes = 3'd2;
      default: beat_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [L2_AWIDTH-1:0] align_addr(input logic [L2_AWIDTH-1:0] a,
                                                      input logic [1:0]           ds);
    align_addr = a;
    if (ds != 2'd0) align_addr[0] = 1'b0;
    if (ds[1])      align_addr[1] = 1'b0;
  endfunction

  state_t                state_q, state_d;
  logic [L2_AWIDTH-1:0]  cur_addr_q, start_q, pend_addr_q;
  logic [TRANS_SIZE-1:0] bytes_left_q, acc_left_q, size_q, pend_size_q;
  logic [1:0]            ds_q, pend_ds_q;
  logic                  cont_q, pend_cont_q, pend_q, eot_q;
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PW:0]           wr_ptr_q, rd_ptr_q;

  logic                  fifo_empty, fifo_full, push, pop, en_ok, acc_done, last_gnt;
  logic                  boundary, load_new, load_pend, reload;
  logic [TRANS_SIZE-1:0] beat_sz, acc_step, gnt_step;
  logic [31:0]           head;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head       = fifo_mem[rd_ptr_q[PW-1:0]];

  assign beat_sz  = TRANS_SIZE'(beat_bytes(ds_q));
  assign acc_step = (acc_left_q < beat_sz) ? acc_left_q : beat_sz;
  assign gnt_step = (bytes_left_q < beat_sz) ? bytes_left_q : beat_sz;

  // A beat accepted in the abort cycle is dropped with the rest of the queue.
  assign push     = bus.ch_valid_i && bus.ch_ready_o && !cfg_clr_i;
  assign pop      = bus.l2_req_o && bus.l2_gnt_i;
  assign en_ok    = cfg_en_i && !cfg_clr_i && (cfg_size_i != '0);
  assign acc_done = push && (acc_left_q == acc_step);
  assign last_gnt = pop && (state_q != S_IDLE) && (bytes_left_q == gnt_step) && !cfg_clr_i;

  // A new window may only start once an aborted head has left the FIFO.
  assign boundary  = ((state_q == S_IDLE) && fifo_empty && !cfg_clr_i) || last_gnt;
  assign load_new  = boundary && en_ok;
  assign load_pend = boundary && !en_ok && pend_q;
  assign reload    = last_gnt && !en_ok && !pend_q && cont_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (cfg_clr_i)                                  state_d = S_IDLE;
    else if (load_new || load_pend || reload)       state_d = S_RUN;
    else if (last_gnt)                              state_d = S_IDLE;
    else if ((state_q == S_RUN) && acc_done)        state_d = S_DRAIN;
  end

  always_comb begin
    bus.ch_ready_o = (state_q == S_RUN) && !fifo_full && (acc_left_q != '0);
    bus.l2_req_o   = !fifo_empty;
    bus.l2_addr_o  = {cur_addr_q[L2_AWIDTH-1:2], 2'b00};
    bus.l2_wdata_o = '0;
    bus.l2_be_o    = '0;
    cfg_en_o       = (state_q != S_IDLE);
    if (!fifo_empty) begin
      case (ds_q)
        2'd0: begin
          bus.l2_wdata_o = {4{head[7:0]}};
          bus.l2_be_o    = 4'b0001 << cur_addr_q[1:0];
        end
        2'd1: begin
          bus.l2_wdata_o = {2{head[15:0]}};
          bus.l2_be_o    = cur_addr_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          bus.l2_wdata_o = head;
          bus.l2_be_o    = 4'b1111;
        end
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_q   <= '0;
      start_q      <= '0;
      size_q       <= '0;
      bytes_left_q <= '0;
      acc_left_q   <= '0;
      ds_q         <= '0;
      cont_q       <= 1'b0;
      eot_q        <= 1'b0;
    end else begin
      eot_q <= last_gnt;
      if (load_new) begin
        cur_addr_q   <= align_addr(cfg_start_addr_i, cfg_datasize_i);
        start_q      <= align_addr(cfg_start_addr_i, cfg_datasize_i);
        size_q       <= cfg_size_i;
        bytes_left_q <= cfg_size_i;
        acc_left_q   <= cfg_size_i;
        ds_q         <= cfg_datasize_i;
        cont_q       <= cfg_continuous_i;
      end else if (load_pend) begin
        cur_addr_q   <= align_addr(pend_addr_q, pend_ds_q);
        start_q      <= align_addr(pend_addr_q, pend_ds_q);
        size_q       <= pend_size_q;
        bytes_left_q <= pend_size_q;
        acc_left_q   <= pend_size_q;
        ds_q         <= pend_ds_q;
        cont_q       <= pend_cont_q;
      end else if (reload) begin
        cur_addr_q   <= start_q;
        bytes_left_q <= size_q;
        acc_left_q   <= size_q;
      end else begin
        if (push) acc_left_q <= acc_left_q - acc_step;
        // After an abort the window counters freeze while the held head drains.
        if (pop && (state_q != S_IDLE)) begin
          cur_addr_q   <= cur_addr_q + L2_AWIDTH'(beat_bytes(ds_q));
          bytes_left_q <= bytes_left_q - gnt_step;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_size_q <= '0;
      pend_ds_q   <= '0;
      pend_cont_q <= 1'b0;
    end else if (cfg_clr_i) begin
      pend_q <= 1'b0;
    end else if (en_ok && !boundary) begin
      pend_q      <= 1'b1;
      pend_addr_q <= cfg_start_addr_i;
      pend_size_q <= cfg_size_i;
      pend_ds_q   <= cfg_datasize_i;
      pend_cont_q <= cfg_continuous_i;
    end else if (boundary) begin
      pend_q <= 1'b0;
    end
  end

  // Abort keeps only the head entry (unless it is granted in the same cycle).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (cfg_clr_i) wr_ptr_q <= rd_ptr_q + {{PW{1'b0}}, !fifo_empty};
      else if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the data array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= bus.ch_data_i;
  end

`ifdef UVMA_UDMA_RX_CH_OVF_CNT_EN
  logic [7:0] ovf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ovf_q <= '0;
    else if (cfg_clr_i) ovf_q <= '0;
    else if (bus.ch_valid_i && !bus.ch_ready_o && cfg_en_o && (ovf_q != 8'hFF))
      ovf_q <= ovf_q + 8'd1;
  end

  assign ovf_cnt_o = ovf_q;
`endif

  assign cfg_pending_o    = pend_q;
  assign cfg_curr_addr_o  = cur_addr_q;
  assign cfg_bytes_left_o = bytes_left_q;
  assign evt_eot_o        = eot_q;

endmodule

// File: tb/tb_uvma_udma_rx_ch_rtl_ctrl.sv
// Directed bench for uvma_udma_rx_ch_rtl_ctrl: beat feeder, L2 write recorder, hand-computed expectations.
module tb_uvma_udma_rx_ch_rtl_ctrl;
  localparam int AW = 19;
  localparam int TS = 20;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [AW-1:0] cfg_start_addr = '0;
  logic [TS-1:0] cfg_size = '0;
  logic [1:0]    cfg_datasize = '0;
  logic          cfg_cont = 1'b0;
  logic          cfg_en = 1'b0;
  logic          cfg_clr = 1'b0;
  logic          cfg_en_o, cfg_pending, evt_eot;
  logic [AW-1:0] cfg_curr_addr;
  logic [TS-1:0] cfg_bytes_left;
`ifdef UVMA_UDMA_RX_CH_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  uvma_udma_rx_ch_rtl_ctrl_if #(.L2_AWIDTH(AW)) bus_if ();

  uvma_udma_rx_ch_rtl_ctrl #(.L2_AWIDTH(AW), .TRANS_SIZE(TS), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .cfg_start_addr_i (cfg_start_addr),
    .cfg_size_i       (cfg_size),
    .cfg_datasize_i   (cfg_datasize),
    .cfg_continuous_i (cfg_cont),
    .cfg_en_i         (cfg_en),
    .cfg_clr_i        (cfg_clr),
    .cfg_en_o         (cfg_en_o),
    .cfg_pending_o    (cfg_pending),
    .cfg_curr_addr_o  (cfg_curr_addr),
    .cfg_bytes_left_o (cfg_bytes_left),
`ifdef UVMA_UDMA_RX_CH_OVF_CNT_EN
    .ovf_cnt_o        (ovf_cnt),
`endif
    .evt_eot_o        (evt_eot),
    .bus              (bus_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_gnt_cyc = 0;
  int          eot_cnt = 0;
  logic        acc_seen = 1'b0;
  logic [31:0] feed_q[$];
  wr_t         wr_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_cfg(input logic [AW-1:0] a, input logic [TS-1:0] s,
                           input logic [1:0] ds, input logic cont);
    cfg_start_addr = a;
    cfg_size       = s;
    cfg_datasize   = ds;
    cfg_cont       = cont;
    cfg_en         = 1'b1;
    tick();
    cfg_en         = 1'b0;
  endtask

  task automatic pulse_clr();
    cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
  endtask

  task automatic wait_eot(input string tag, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!evt_eot && n < limit);
    check(tag, evt_eot, 1'b1);
  endtask

  task automatic check_wr(input string tag, input int i, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    if (i < wr_q.size()) begin
      check({tag, "_addr"}, wr_q[i].addr, a);
      check({tag, "_data"}, wr_q[i].data, d);
      check({tag, "_be"},   wr_q[i].be,   be);
    end else begin
      check({tag, "_missing"}, wr_q.size(), i + 1);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_if.l2_req_o && bus_if.l2_gnt_i) begin
      wr_q.push_back('{bus_if.l2_addr_o, bus_if.l2_wdata_o, bus_if.l2_be_o});
      last_gnt_cyc <= cyc;
    end
    if (evt_eot) eot_cnt <= eot_cnt + 1;
    acc_seen <= bus_if.ch_valid_i && bus_if.ch_ready_o;
  end

  // Beat feeder: presents feed_q head, advances after each observed handshake.
  initial begin
    bus_if.ch_valid_i = 1'b0;
    bus_if.ch_data_i  = '0;
    forever begin
      @(posedge clk);
      if (acc_seen && feed_q.size() > 0) void'(feed_q.pop_front());
      #1;
      bus_if.ch_valid_i = (feed_q.size() > 0);
      bus_if.ch_data_i  = (feed_q.size() > 0) ? feed_q[0] : 32'h0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    logic [7:0] b;
    bus_if.l2_gnt_i = 1'b0;
    ticks(3);
    reset_n = 1'b1;
    tick();

    check("rst_en",     cfg_en_o, 1'b0);
    check("rst_pend",   cfg_pending, 1'b0);
    check("rst_req",    bus_if.l2_req_o, 1'b0);
    check("rst_ready",  bus_if.ch_ready_o, 1'b0);
    check("rst_eot",    evt_eot, 1'b0);
    check("rst_addr",   cfg_curr_addr, 0);
    check("rst_left",   cfg_bytes_left, 0);
    check("rst_wdata",  bus_if.l2_wdata_o, 0);

    // 8b window: one byte lane per beat, all in word 0x100.
    wr_q.delete();
    bus_if.l2_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) feed_q.push_back(32'hA1 + i);
    start_cfg(19'h100, 20'd4, 2'd0, 1'b0);
    wait_eot("t1_eot", 30);
    check("t1_eot_lat", cyc - last_gnt_cyc, 1);
    check("t1_en_off",  cfg_en_o, 1'b0);
    tick();
    check("t1_nwr", wr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      b = 8'hA1 + 8'(i);
      check_wr("t1_wr", i, 19'h100, {4{b}}, 4'b0001 << i);
    end
    check("t1_left", cfg_bytes_left, 0);
    check("t1_addr", cfg_curr_addr, 19'h104);

    // 32b, 5 beats with grant held low: FIFO fills and the stream stalls.
    wr_q.delete();
    bus_if.l2_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++) feed_q.push_back(32'hD0D0_0000 + i);
    start_cfg(19'h300, 20'd20, 2'd2, 1'b0);
    ticks(8);
    check("t2_ready_low", bus_if.ch_ready_o, 1'b0);
    check("t2_req",       bus_if.l2_req_o, 1'b1);
    check("t2_addr",      bus_if.l2_addr_o, 19'h300);
    check("t2_data",      bus_if.l2_wdata_o, 32'hD0D0_0000);
    check("t2_be",        bus_if.l2_be_o, 4'hF);
    check("t2_left_full", cfg_bytes_left, 20);
    ticks(2);
    check("t2_addr_hold", bus_if.l2_addr_o, 19'h300);
    check("t2_data_hold", bus_if.l2_wdata_o, 32'hD0D0_0000);
    bus_if.l2_gnt_i = 1'b1;
    wait_eot("t2_eot", 30);
    tick();
    check("t2_nwr", wr_q.size(), 5);
    for (int i = 0; i < 5; i++)
      check_wr("t2_wr", i, 19'h300 + 19'(4 * i), 32'hD0D0_0000 + i, 4'hF);
    check("t2_left", cfg_bytes_left, 0);
    check("t2_en_off", cfg_en_o, 1'b0);

    // 16b continuous, unaligned start 0x201 masked to 0x200; two identical passes.
    wr_q.delete();
    e0 = eot_cnt;
    for (int i = 0; i < 6; i++) feed_q.push_back(32'h0000_B001 + i);
    start_cfg(19'h201, 20'd6, 2'd1, 1'b1);
    wait_eot("t3_eot1", 30);
    check("t3_reload1", cfg_curr_addr, 19'h200);
    check("t3_busy1",   cfg_en_o, 1'b1);
    wait_eot("t3_eot2", 30);
    check("t3_reload2", cfg_curr_addr, 19'h200);
    check("t3_busy2",   cfg_en_o, 1'b1);
    pulse_clr();
    tick();
    check("t3_idle", cfg_en_o, 1'b0);
    check("t3_neot", eot_cnt - e0, 2);
    check("t3_nwr",  wr_q.size(), 6);
    for (int p = 0; p < 2; p++) begin
      check_wr("t3_wr", 3 * p + 0, 19'h200, {2{16'hB001 + 16'(3 * p + 0)}}, 4'b0011);
      check_wr("t3_wr", 3 * p + 1, 19'h200, {2{16'hB001 + 16'(3 * p + 1)}}, 4'b1100);
      check_wr("t3_wr", 3 * p + 2, 19'h204, {2{16'hB001 + 16'(3 * p + 2)}}, 4'b0011);
    end

    // Pending config (second request overwrites the first) taken at EOT without going idle.
    wr_q.delete();
    e0 = eot_cnt;
    for (int i = 0; i < 3; i++) feed_q.push_back(32'hE000_0000 + i);
    start_cfg(19'h000, 20'd8, 2'd2, 1'b0);
    start_cfg(19'h500, 20'd4, 2'd2, 1'b0);
    start_cfg(19'h400, 20'd4, 2'd2, 1'b0);
    check("t4_pend", cfg_pending, 1'b1);
    wait_eot("t4_eot1", 30);
    check("t4_pend_clr", cfg_pending, 1'b0);
    check("t4_busy",     cfg_en_o, 1'b1);
    check("t4_addr",     cfg_curr_addr, 19'h400);
    wait_eot("t4_eot2", 30);
    tick();
    check("t4_neot", eot_cnt - e0, 2);
    check("t4_nwr",  wr_q.size(), 3);
    check_wr("t4_wr", 0, 19'h000, 32'hE000_0000, 4'hF);
    check_wr("t4_wr", 1, 19'h004, 32'hE000_0001, 4'hF);
    check_wr("t4_wr", 2, 19'h400, 32'hE000_0002, 4'hF);
    check("t4_idle", cfg_en_o, 1'b0);

    // Abort with ungranted head and three queued; en in the same cycle is dropped.
    wr_q.delete();
    e0 = eot_cnt;
    bus_if.l2_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++) feed_q.push_back(32'hF000_0000 + i);
    start_cfg(19'h600, 20'd16, 2'd2, 1'b0);
    ticks(6);
    cfg_start_addr = 19'h700;
    cfg_size       = 20'd4;
    cfg_en         = 1'b1;
    pulse_clr();
    cfg_en         = 1'b0;
    check("t5_idle",  cfg_en_o, 1'b0);
    check("t5_pend",  cfg_pending, 1'b0);
    check("t5_ready", bus_if.ch_ready_o, 1'b0);
    check("t5_req",   bus_if.l2_req_o, 1'b1);
    check("t5_haddr", bus_if.l2_addr_o, 19'h600);
    check("t5_hdata", bus_if.l2_wdata_o, 32'hF000_0000);
    ticks(3);
    check("t5_req_hold", bus_if.l2_req_o, 1'b1);
    bus_if.l2_gnt_i = 1'b1;
    ticks(5);
    check("t5_nwr",   wr_q.size(), 1);
    check_wr("t5_wr", 0, 19'h600, 32'hF000_0000, 4'hF);
    check("t5_req_off", bus_if.l2_req_o, 1'b0);
    check("t5_noeot", eot_cnt - e0, 0);
    check("t5_still_idle", cfg_en_o, 1'b0);

    // Zero-size start is ignored.
    start_cfg(19'h800, 20'd0, 2'd2, 1'b0);
    tick();
    check("t6_zero_en",   cfg_en_o, 1'b0);
    check("t6_zero_pend", cfg_pending, 1'b0);

`ifdef UVMA_UDMA_RX_CH_OVF_CNT_EN
    // Stalled stream with valid high saturates the overflow counter.
    bus_if.l2_gnt_i = 1'b0;
    for (int i = 0; i < 10; i++) feed_q.push_back(32'hC000_0000 + i);
    start_cfg(19'hA00, 20'd40, 2'd2, 1'b0);
    ticks(310);
    check("ovf_sat", ovf_cnt, 8'd255);
    feed_q.delete();
    pulse_clr();
    check("ovf_clr", ovf_cnt, 8'd0);
    bus_if.l2_gnt_i = 1'b1;
    ticks(3);
`endif

    // Reset mid-transfer returns everything to the reset state without EOT.
    e0 = eot_cnt;
    bus_if.l2_gnt_i = 1'b0;
    feed_q.push_back(32'h1234_5678);
    feed_q.push_back(32'h9ABC_DEF0);
    start_cfg(19'hB00, 20'd8, 2'd2, 1'b0);
    ticks(3);
    reset_n = 1'b0;
    #1;
    check("mrst_en",   cfg_en_o, 1'b0);
    check("mrst_req",  bus_if.l2_req_o, 1'b0);
    check("mrst_addr", cfg_curr_addr, 0);
    check("mrst_left", cfg_bytes_left, 0);
    feed_q.delete();
    tick();
    reset_n = 1'b1;
    ticks(2);
    check("mrst_noeot", eot_cnt - e0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
